uart_echo_fifo: RTL
===================

# uart_echo_fifo

Parametrised UART echo engine: receives serial frames on `uart_rx`, checks framing and parity, buffers good characters in an internal FIFO, and retransmits them on `uart_tx`. It sits directly behind the board UART pins, in the same position as the current fixed 8N1 loopback. It adds:

- configurable data bits, parity and stop bits;
- buffering, so back-to-back input does not depend on transmit timing;
- error and overflow reporting;
- an echo gate, so software or a bench can hold data in the buffer.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz
- `UART_BPS`, 115200, baud rate; `BAUD_DIV = CLK_FREQ / UART_BPS` (integer division, must be ≥ 4)
- `DATA_BITS`, 8, data bits per frame, 5..8
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, transmitted stop bits, 1 or 2
- `FIFO_DEPTH`, 16, buffer entries, power of two, ≥ 2
- `clk  in  1` system clock; everything is in this domain
- `rst_n  in  1` asynchronous active-low reset
- `uart_rx  in  1` serial input, asynchronous, idle high
- `uart_tx  out  1` serial output, registered, idle high
- `echo_en  in  1` 1 = TX may pop the FIFO; 0 = TX stays idle and data is held
- `fifo_count  out  $clog2(FIFO_DEPTH+1)` current occupancy
- `rx_frame_err  out  1` one-cycle pulse: stop bit sampled low
- `rx_parity_err  out  1` one-cycle pulse: parity mismatch
- `rx_overflow  out  1` one-cycle pulse: good character dropped because the FIFO was full

## Operation
- Reset values:
  - `uart_tx` = 1, all error pulses = 0, `fifo_count` = 0;
  - RX and TX FSMs in IDLE, FIFO pointers 0;
  - synchroniser flops = 1.
- **RX input path:** `uart_rx` passes through a 2-flop synchroniser. All RX decisions use the synchronised signal.
- **RX FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a 1→0 transition of the synchronised input.
  - START: wait `BAUD_DIV/2` cycles, then sample. If the sample is 1, treat it as a glitch and return to IDLE with no error. If 0, go to DATA.
  - DATA: sample every `BAUD_DIV` cycles, LSB first, `DATA_BITS` samples.
  - PARITY: entered only if `PARITY` ≠ 0. Sample once after `BAUD_DIV` cycles.
  - STOP: sample once after `BAUD_DIV` cycles.
  - STOP → IDLE immediately after the stop sample. The receiver checks only the first stop bit, whatever `STOP_BITS` is.
- **RX character disposition at the stop sample:**
  - stop = 0 → `rx_frame_err` pulses, character discarded. Framing error takes priority over parity error.
  - parity wrong → `rx_parity_err` pulses, character discarded. Odd parity means data plus parity bit has an odd number of ones.
  - otherwise → push request to the FIFO.
- **FIFO:** stores `DATA_BITS`-wide entries; occupancy ranges 0..`FIFO_DEPTH`.
  - A push is accepted if `fifo_count` < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - A refused push pulses `rx_overflow` and the character is lost.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **TX FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `echo_en` = 1 and `fifo_count` ≠ 0, pop one entry, load the shift register, go to START.
  - START: drive 0 for `BAUD_DIV` cycles.
  - DATA: drive `DATA_BITS` bits LSB first, `BAUD_DIV` cycles each.
  - PARITY: drive the parity bit if enabled, `BAUD_DIV` cycles.
  - STOP: drive 1 for `STOP_BITS × BAUD_DIV` cycles, then return to IDLE.
- `echo_en` is sampled only in TX IDLE. Deasserting it mid-frame completes the current frame.
- Reset asserted mid-frame aborts both FSMs immediately. `uart_tx` returns to 1 asynchronously and FIFO contents are discarded.

## Timing
- Pop occurs in the cycle TX IDLE sees `echo_en` & non-empty. `uart_tx` falls in the next cycle.
- TX frame length = (1 + `DATA_BITS` + (`PARITY` ≠ 0) + `STOP_BITS`) × `BAUD_DIV` cycles.
- Back-to-back TX:
  - the next pop is in the first IDLE cycle after the stop period;
  - the next start bit begins one cycle after that;
  - inter-frame gap = exactly 1 cycle beyond the stop period.
- RX FIFO push and error pulses occur 1 cycle after the stop-bit sample.
- `fifo_count` updates in the cycle after the push or pop.
- RX is ready for a new start edge in the cycle after the stop sample, so a 1-stop-bit sender at the same baud is never missed.

## Test plan
Bench parameters: `CLK_FREQ` = 1000000, `UART_BPS` = 100000, so `BAUD_DIV` = 10.

- **8N1 echo:** send 0xA5 with `echo_en` = 1 → `uart_tx` emits 0xA5 LSB first, each bit 10 cycles wide; no error pulses; `fifo_count` returns to 0.
- **Parity:** `PARITY` = 2 (even). Send 0x07 with parity bit 1 → echoed with parity bit 1. Send 0x07 with parity bit 0 → one `rx_parity_err` pulse, nothing echoed.
- **Framing and glitch:** send 0x3C with stop = 0 → `rx_frame_err` pulse, `fifo_count` stays 0. Apply a 3-cycle low glitch → no error, no push.
- **Overflow:** `FIFO_DEPTH` = 4, `echo_en` = 0, send 5 bytes 0x01..0x05 → `fifo_count` = 4, one `rx_overflow` on the 5th byte. Then set `echo_en` = 1 → 0x01..0x04 transmitted in order, gap of 1 cycle between frames.
- **Format:** `DATA_BITS` = 5, `STOP_BITS` = 2, odd parity. Send 0x15 → frame = 1 + 5 + 1 + 2 bits = 90 cycles, parity bit 0.
- **Reset mid-frame:** assert `rst_n` = 0 during TX bit 3 → `uart_tx` = 1 immediately. After release, `fifo_count` = 0 and no transmission until new RX data arrives.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: configurable UART receiver feeding a character FIFO that a
// gated transmitter drains, echoing every good frame back out on uart_tx.
module uart_echo_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             uart_rx,
    output logic                             uart_tx,
    input  logic                             echo_en,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             rx_frame_err,
    output logic                             rx_parity_err,
    output logic                             rx_overflow
);
    localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(2 * BAUD_DIV + 1);
    localparam logic [BW-1:0] BIT_END  = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_END = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS * BAUD_DIV - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic PAR_ODD = (PARITY == 1);
    localparam logic HAS_PAR = (PARITY != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic                 sync1_q, sync2_q, prev_q;
    state_t               rx_st_q;
    logic [BW-1:0]        rx_cnt_q;
    logic [2:0]           rx_bit_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic                 rx_par_q;
    logic                 push_q;
    logic [DATA_BITS-1:0] push_data_q;
    logic                 par_bad;

    assign par_bad = HAS_PAR && (((^rx_sh_q) ^ rx_par_q) != PAR_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            rx_st_q       <= IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_sh_q       <= '0;
            rx_par_q      <= 1'b0;
            push_q        <= 1'b0;
            push_data_q   <= '0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            sync1_q       <= uart_rx;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            rx_cnt_q      <= rx_cnt_q + 1'b1;
            push_q        <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            case (rx_st_q)
                IDLE: begin
                    rx_cnt_q <= '0;
                    if (prev_q && !sync2_q) rx_st_q <= START;
                end
                START: if (rx_cnt_q == HALF_END) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rx_st_q  <= sync2_q ? IDLE : DATA;
                end
                DATA: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= rx_bit_q + 1'b1;
                    rx_sh_q  <= {sync2_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) rx_st_q <= HAS_PAR ? PAR : STOP;
                end
                PAR: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q <= '0;
                    rx_par_q <= sync2_q;
                    rx_st_q  <= STOP;
                end
                default: if (rx_cnt_q == BIT_END) begin
                    // framing error wins over parity; only the first stop bit is checked
                    rx_st_q       <= IDLE;
                    rx_frame_err  <= !sync2_q;
                    rx_parity_err <= sync2_q && par_bad;
                    push_q        <= sync2_q && !par_bad;
                    push_data_q   <= rx_sh_q;
                end
            endcase
        end
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [CW-1:0]        count_q, count_d;
    state_t               tx_st_q;
    logic                 pop, push_ok;

    assign pop     = (tx_st_q == IDLE) && echo_en && (count_q != '0);
    assign push_ok = push_q && ((count_q != FULL) || pop);
    assign count_d = count_q + CW'(push_ok) - CW'(pop);
    assign fifo_count = count_q;

    always_ff @(posedge clk) if (push_ok) mem_q[wr_q] <= push_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            rx_overflow <= 1'b0;
        end else begin
            wr_q        <= wr_q + AW'(push_ok);
            rd_q        <= rd_q + AW'(pop);
            count_q     <= count_d;
            rx_overflow <= push_q && !push_ok;
        end
    end

    logic [BW-1:0]        tx_cnt_q;
    logic [2:0]           tx_bit_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_par_q, tx_q;

    assign uart_tx = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q  <= IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            case (tx_st_q)
                IDLE: begin
                    tx_cnt_q <= '0;
                    tx_q     <= 1'b1;
                    if (pop) begin
                        tx_sh_q  <= mem_q[rd_q];
                        tx_par_q <= (^mem_q[rd_q]) ^ PAR_ODD;
                        tx_bit_q <= '0;
                        tx_q     <= 1'b0;
                        tx_st_q  <= START;
                    end
                end
                START: if (tx_cnt_q == BIT_END) begin
                    tx_cnt_q <= '0;
                    tx_q     <= tx_sh_q[0];
                    tx_st_q  <= DATA;
                end
                DATA: if (tx_cnt_q == BIT_END) begin
                    tx_cnt_q <= '0;
                    tx_bit_q <= tx_bit_q + 1'b1;
                    tx_sh_q  <= tx_sh_q >> 1;
                    tx_q     <= tx_sh_q[1];
                    if (tx_bit_q == LAST_BIT) begin
                        tx_st_q <= HAS_PAR ? PAR : STOP;
                        tx_q    <= HAS_PAR ? tx_par_q : 1'b1;
                    end
                end
                PAR: if (tx_cnt_q == BIT_END) begin
                    tx_cnt_q <= '0;
                    tx_q     <= 1'b1;
                    tx_st_q  <= STOP;
                end
                default: if (tx_cnt_q == STOP_END) tx_st_q <= IDLE;
            endcase
        end
    end
endmodule
